vram_arbiter: RTL and testbench

- Responder and bus-owner side of the VPU DMA interface; sits between the shared video/system RAM, the CPU bus and the VPU.
- On VPU `hold`, halts the CPU, hands the RAM port to the VPU address (`vaddr`/`vramcs`) and returns read data on `vdata`.
- On `hold` release, returns the RAM port to the CPU.
- Keeps a saturating count of stolen cycles for software profiling.

---
 rtl/vram_arbiter_pkg.sv | 23 ++
 rtl/vram_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_vram_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// vram_arbiter_pkg
// Shared types and constants for the VPU/CPU video RAM arbiter.
//   state_t   : arbiter FSM encoding (CPU, DRAIN, VIDEO, RETURN)
//   BUSY_MAX  : saturation value of the stolen-cycle counter
//   sat_inc() : saturating 16-bit increment used by the profiling counter
// -----------------------------------------------------------------------------
package vram_arbiter_pkg;

    typedef enum logic [1:0] {
        CPU    = 2'b00,   // RAM owned by the CPU
        DRAIN  = 2'b01,   // CPU halted, RAM idle, grant pending
        VIDEO  = 2'b10,   // RAM owned by the VPU
        RETURN = 2'b11    // CPU still halted, RAM idle, handing back
    } state_t;

    localparam logic [15:0] BUSY_MAX = 16'hFFFF;

    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        return (value == BUSY_MAX) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/vram_arbiter.sv
// -----------------------------------------------------------------------------
// vram_arbiter
// Bus owner of the shared video/system RAM. On a VPU hold request the CPU is
// halted and the RAM port is handed to the VPU DMA address; on release the
// port returns to the CPU. A saturating counter records stolen (VIDEO) cycles.
//
// Optional feature (macro VRAM_ARBITER_HOLD_TIMEOUT_EN):
//   forces a release after HOLD_TIMEOUT VIDEO cycles, sets a sticky
//   timeout_flag, and refuses a new grant until hold has been seen low.
//   Without the macro the HOLD_TIMEOUT parameter is unused and
//   timeout_flag is tied 0.
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   hold              VPU bus request
//   vramcs, vaddr     VPU RAM select / DMA address (meaningful while granted)
//   vdata             read data to VPU (unregistered copy of mem_do)
//   cpu_addr, cpu_di  CPU address / write data
//   cpu_rw, cpu_cs    CPU direction (1 = read) / RAM select
//   cpu_do            read data to CPU (unregistered copy of mem_do)
//   cpu_halt          stalls the CPU bus cycle while high
//   mem_*             synchronous RAM port (1-clock read latency)
//   dma_active        high while in VIDEO
//   clr_stats         synchronous clear of busy_cycles (and timeout_flag)
//   busy_cycles       saturating count of VIDEO cycles
//   timeout_flag      sticky forced-release indicator
// -----------------------------------------------------------------------------
module vram_arbiter
    import vram_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 16,
    parameter int HOLD_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    input  logic              vramcs,
    input  logic [15:0]       vaddr,
    output logic [7:0]        vdata,
    input  logic [15:0]       cpu_addr,
    input  logic [7:0]        cpu_di,
    output logic [7:0]        cpu_do,
    input  logic              cpu_rw,
    input  logic              cpu_cs,
    output logic              cpu_halt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_di,
    input  logic [7:0]        mem_do,
    output logic              mem_ce,
    output logic              mem_we,
    output logic              dma_active,
    input  logic              clr_stats,
    output logic [15:0]       busy_cycles,
    output logic              timeout_flag
);

    state_t state;
    logic   force_release;   // timeout ends the VIDEO burst on this edge
    logic   hold_block;      // grant refused until hold is seen low

`ifdef VRAM_ARBITER_HOLD_TIMEOUT_EN
    logic [7:0] hold_cnt;
    logic       timeout_q;

    // hold_cnt counts completed VIDEO cycles; releasing when the next edge
    // would reach HOLD_TIMEOUT gives exactly HOLD_TIMEOUT VIDEO cycles.
    assign force_release = (state == VIDEO) &&
                           ((hold_cnt + 8'd1) == 8'(HOLD_TIMEOUT));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_cnt   <= 8'd0;
            hold_block <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            // DRAIN always precedes VIDEO, so clearing here is a clear on entry.
            if (state == DRAIN)
                hold_cnt <= 8'd0;
            else if (state == VIDEO)
                hold_cnt <= hold_cnt + 8'd1;

            if (force_release)
                hold_block <= 1'b1;
            else if (!hold)
                hold_block <= 1'b0;

            if (clr_stats)
                timeout_q <= 1'b0;
            else if (force_release)
                timeout_q <= 1'b1;
        end
    end

    assign timeout_flag = timeout_q;
`else
    assign force_release = 1'b0;
    assign hold_block    = 1'b0;
    assign timeout_flag  = 1'b0;
`endif

    // Arbiter FSM with registered cpu_halt / dma_active. CPU->DRAIN->VIDEO
    // takes exactly two edges after hold is sampled: the VPU drives vramcs
    // two clocks after raising hold without waiting for an acknowledge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= CPU;
            cpu_halt   <= 1'b0;
            dma_active <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            case (state)
                CPU: begin
                    if (hold && !hold_block) begin
                        state    <= DRAIN;
                        cpu_halt <= 1'b1;
                    end
                end
                DRAIN: begin
                    // No shortcut if hold already dropped: VIDEO lasts >= 1 cycle.
                    state      <= VIDEO;
                    dma_active <= 1'b1;
                end
                VIDEO: begin
                    if (!hold || force_release) begin
                        state      <= RETURN;
                        dma_active <= 1'b0;
                    end
                end
                RETURN: begin
                    // hold is ignored here so the CPU always gets one cycle.
                    state    <= CPU;
                    cpu_halt <= 1'b0;
                end
                default: begin
                    state      <= CPU;
                    cpu_halt   <= 1'b0;
                    dma_active <= 1'b0;
                end
            endcase
        end
    end

    // RAM port mux, purely a function of state so the grant is visible in
    // the same cycle the FSM enters VIDEO.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        mem_addr = cpu_addr[ADDR_W-1:0];
        mem_di   = cpu_di;
        mem_ce   = 1'b0;
        mem_we   = 1'b0;
        case (state)
            CPU: begin
                mem_ce = cpu_cs;
                mem_we = cpu_cs & ~cpu_rw;
            end
            VIDEO: begin
                mem_addr = vaddr[ADDR_W-1:0];
                mem_ce   = vramcs;   // VPU is read-only
            end
            default: ;
        endcase
    end

    // Read data is passed straight through; the VPU holds each address for
    // two clocks and samples at the end of the second.
    assign vdata  = mem_do;
    assign cpu_do = mem_do;

    // Stolen-cycle profiling counter; clear wins over increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            busy_cycles <= 16'd0;
        else if (clr_stats)
            busy_cycles <= 16'd0;
        else if (state == VIDEO)
            busy_cycles <= sat_inc(busy_cycles);
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vram_arbiter
// Directed stimulus for vram_arbiter with a behavioural synchronous RAM.
// Stimulus pushes expected values into a scoreboard queue; a monitor on the
// falling edge pops each entry and compares it with the DUT output it names.
// -----------------------------------------------------------------------------
module tb_vram_arbiter;
    import vram_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        hold = 1'b0;
    logic        vramcs = 1'b0;
    logic [15:0] vaddr = 16'h0000;
    logic [15:0] cpu_addr = 16'h1234;
    logic [7:0]  cpu_di = 8'h00;
    logic        cpu_rw = 1'b1;
    logic        cpu_cs = 1'b0;
    logic        clr_stats = 1'b0;

    logic [7:0]  vdata;
    logic [7:0]  cpu_do;
    logic        cpu_halt;
    logic [15:0] mem_addr;
    logic [7:0]  mem_di;
    logic [7:0]  mem_do = 8'h00;
    logic        mem_ce;
    logic        mem_we;
    logic        dma_active;
    logic [15:0] busy_cycles;
    logic        timeout_flag;

    always #5 clk = ~clk;

    vram_arbiter #(.ADDR_W(16), .HOLD_TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .hold(hold), .vramcs(vramcs), .vaddr(vaddr),
        .vdata(vdata), .cpu_addr(cpu_addr), .cpu_di(cpu_di), .cpu_do(cpu_do),
        .cpu_rw(cpu_rw), .cpu_cs(cpu_cs), .cpu_halt(cpu_halt),
        .mem_addr(mem_addr), .mem_di(mem_di), .mem_do(mem_do),
        .mem_ce(mem_ce), .mem_we(mem_we), .dma_active(dma_active),
        .clr_stats(clr_stats), .busy_cycles(busy_cycles),
        .timeout_flag(timeout_flag)
    );

    // Synchronous RAM, one clock read latency.
    logic [7:0] ram [0:65535];
    always @(posedge clk) begin
        if (mem_ce) begin
            if (mem_we) ram[mem_addr] <= mem_di;
            else        mem_do <= ram[mem_addr];
        end
    end

    // ---------------- scoreboard ----------------
    typedef enum {S_HALT, S_DMA, S_ADDR, S_CE, S_WE, S_VDATA, S_BUSY, S_TOF, S_RAM4000} sig_e;
    typedef struct {
        string       name;
        sig_e        sig;
        logic [15:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic expect_sig(input string name, input sig_e sig, input logic [15:0] exp);
        exp_t e;
        e.name = name;
        e.sig  = sig;
        e.exp  = exp;
        sb_q.push_back(e);
    endtask

    function automatic logic [15:0] observe(input sig_e s);
        case (s)
            S_HALT:    return 16'(cpu_halt);
            S_DMA:     return 16'(dma_active);
            S_ADDR:    return mem_addr;
            S_CE:      return 16'(mem_ce);
            S_WE:      return 16'(mem_we);
            S_VDATA:   return 16'(vdata);
            S_BUSY:    return busy_cycles;
            S_TOF:     return 16'(timeout_flag);
            S_RAM4000: return 16'(ram[16'h4000]);
            default:   return 16'hxxxx;
        endcase
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: read data is only presented to the VPU while it is granted.
    always @(negedge clk) begin : monitor
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (e.sig == S_VDATA && dma_active !== 1'b1)
                check({e.name, "_grant"}, 16'(dma_active), 16'd1);
            else
                check(e.name, observe(e.sig), e.exp);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Async reset while the VPU owns the bus.
    task automatic run_reset_mid_video();
        hold = 1'b1;
        step(2);                                   // VIDEO
        expect_sig("rv_dma_before", S_DMA, 16'd1);
        step(1);
        #1;
        rst = 1'b0;                                // between edges
        expect_sig("rv_halt_async", S_HALT, 16'd0);
        expect_sig("rv_dma_async",  S_DMA,  16'd0);
        expect_sig("rv_busy_async", S_BUSY, 16'd0);
        expect_sig("rv_ce_async",   S_CE,   16'd0);
        step(1);
        hold = 1'b0;
        rst  = 1'b1;
        step(2);
        expect_sig("rv_halt_after", S_HALT, 16'd0);
        step(1);
    endtask

`ifndef VRAM_ARBITER_HOLD_TIMEOUT_EN
    logic [7:0] burst [4];

    task automatic run_burst();
        burst[0] = 8'h11; burst[1] = 8'h22; burst[2] = 8'h33; burst[3] = 8'h44;
        hold = 1'b1;                                // sampled at E1
        step(1);                                    // E1: DRAIN
        expect_sig("g_halt_e1", S_HALT, 16'd1);
        expect_sig("g_dma_e1",  S_DMA,  16'd0);
        expect_sig("g_ce_e1",   S_CE,   16'd0);
        step(1);                                    // E2: VIDEO
        for (int i = 0; i < 4; i++) begin
            vaddr  = 16'h4000 + 16'(i);
            vramcs = 1'b1;
            if (i == 0) begin
                expect_sig("g_dma_e2",  S_DMA,  16'd1);
                expect_sig("g_addr_e2", S_ADDR, 16'h4000);
                expect_sig("g_halt_e2", S_HALT, 16'd1);
            end
            expect_sig("b_we_1st", S_WE, 16'd0);
            step(1);
            expect_sig($sformatf("b_vdata%0d", i), S_VDATA, 16'(burst[i]));
            expect_sig("b_we_2nd", S_WE, 16'd0);
            step(1);
        end
        hold   = 1'b0;
        vramcs = 1'b0;
        step(1);                                    // RETURN
        expect_sig("b_ret_halt", S_HALT, 16'd1);
        expect_sig("b_ret_dma",  S_DMA,  16'd0);
        expect_sig("b_ret_ce",   S_CE,   16'd0);
        expect_sig("b_busy",     S_BUSY, 16'd9);
        step(1);                                    // CPU
        expect_sig("b_cpu_halt", S_HALT, 16'd0);
        expect_sig("b_cpu_busy", S_BUSY, 16'd9);
    endtask

    task automatic run_collision();
        cpu_cs = 1'b1; cpu_rw = 1'b0; cpu_addr = 16'h4000; cpu_di = 8'h5A;
        hold = 1'b1;
        expect_sig("c_we",   S_WE,   16'd1);
        expect_sig("c_ce",   S_CE,   16'd1);
        expect_sig("c_addr", S_ADDR, 16'h4000);
        expect_sig("c_halt", S_HALT, 16'd0);
        step(1);                                    // DRAIN, write landed
        cpu_di = 8'hA5;                             // stalled next cycle
        expect_sig("c_ram_5a",    S_RAM4000, 16'h005A);
        expect_sig("c_halt_dr",   S_HALT,    16'd1);
        expect_sig("c_we_dr",     S_WE,      16'd0);
        step(1);                                    // VIDEO
        expect_sig("c_we_vid",  S_WE,  16'd0);
        expect_sig("c_dma_vid", S_DMA, 16'd1);
        hold = 1'b0;
        step(1);                                    // RETURN
        expect_sig("c_ram_held", S_RAM4000, 16'h005A);
        step(1);                                    // CPU
        expect_sig("c_halt_rel", S_HALT, 16'd0);
        expect_sig("c_we_rel",   S_WE,   16'd1);
        expect_sig("c_busy",     S_BUSY, 16'd10);
        step(1);                                    // stalled write completes
        cpu_cs = 1'b0; cpu_rw = 1'b1;
        expect_sig("c_ram_a5", S_RAM4000, 16'h00A5);
    endtask

    task automatic run_back_to_back_and_saturation();
        hold = 1'b1;
        step(1);                                    // DRAIN
        hold = 1'b0;
        expect_sig("d_halt", S_HALT, 16'd1);
        expect_sig("d_dma",  S_DMA,  16'd0);
        step(1);                                    // VIDEO despite hold low
        expect_sig("d_dma_vid", S_DMA, 16'd1);
        step(1);                                    // RETURN
        expect_sig("d_ret_dma",  S_DMA,  16'd0);
        expect_sig("d_ret_halt", S_HALT, 16'd1);
        expect_sig("d_busy",     S_BUSY, 16'd11);
        step(1);                                    // CPU
        expect_sig("d_cpu_halt", S_HALT, 16'd0);

        hold = 1'b1;
        step(2);                                    // VIDEO
        hold = 1'b0;
        step(1);                                    // RETURN
        hold = 1'b1;                                // reasserted in RETURN
        expect_sig("k_ret_halt", S_HALT, 16'd1);
        expect_sig("k_ret_dma",  S_DMA,  16'd0);
        step(1);                                    // CPU for one cycle
        expect_sig("k_cpu_halt", S_HALT, 16'd0);
        expect_sig("k_cpu_dma",  S_DMA,  16'd0);
        expect_sig("k_busy",     S_BUSY, 16'd12);
        step(1);                                    // DRAIN
        expect_sig("k_dr_halt", S_HALT, 16'd1);
        expect_sig("k_dr_dma",  S_DMA,  16'd0);
        step(1);                                    // VIDEO, held from here
        expect_sig("k_vid_dma", S_DMA,  16'd1);
        expect_sig("s_busy12",  S_BUSY, 16'd12);

        step(65534 - 12);
        expect_sig("s_fffe", S_BUSY, 16'hFFFE);
        step(1);
        expect_sig("s_ffff", S_BUSY, 16'hFFFF);
        step(3);
        expect_sig("s_stick", S_BUSY, 16'hFFFF);
        clr_stats = 1'b1;
        step(1);                                    // clear beats increment
        clr_stats = 1'b0;
        expect_sig("s_clr",   S_BUSY, 16'd0);
        expect_sig("s_clr_dma", S_DMA, 16'd1);
        step(1);
        expect_sig("s_one", S_BUSY, 16'd1);
        hold = 1'b0;
        step(2);                                    // RETURN, CPU
        expect_sig("s_end_busy", S_BUSY, 16'd2);
        expect_sig("s_end_halt", S_HALT, 16'd0);
        expect_sig("s_end_tof",  S_TOF,  16'd0);
    endtask
`else
    task automatic run_timeout();
        hold = 1'b1;
        step(2);                                    // VIDEO entry
        expect_sig("t_dma_entry", S_DMA, 16'd1);
        expect_sig("t_tof_entry", S_TOF, 16'd0);
        step(7);                                    // 7 VIDEO cycles done
        expect_sig("t_dma_7", S_DMA, 16'd1);
        step(1);                                    // forced RETURN after 8
        expect_sig("t_ret_dma",  S_DMA,  16'd0);
        expect_sig("t_ret_halt", S_HALT, 16'd1);
        expect_sig("t_tof",      S_TOF,  16'd1);
        expect_sig("t_busy",     S_BUSY, 16'd8);
        step(1);                                    // CPU
        expect_sig("t_cpu_halt", S_HALT, 16'd0);
        step(3);                                    // hold still high, no grant
        expect_sig("t_blk_halt", S_HALT, 16'd0);
        expect_sig("t_blk_dma",  S_DMA,  16'd0);
        expect_sig("t_tof_sticky", S_TOF, 16'd1);
        hold = 1'b0;
        step(1);
        hold = 1'b1;
        step(1);                                    // DRAIN
        expect_sig("t_regrant_halt", S_HALT, 16'd1);
        step(1);
        expect_sig("t_regrant_dma", S_DMA, 16'd1);
        clr_stats = 1'b1;
        step(1);
        clr_stats = 1'b0;
        expect_sig("t_tof_clr",  S_TOF,  16'd0);
        expect_sig("t_busy_clr", S_BUSY, 16'd0);
        hold = 1'b0;
        step(3);
    endtask
`endif

    initial begin
        ram[16'h4000] = 8'h11;
        ram[16'h4001] = 8'h22;
        ram[16'h4002] = 8'h33;
        ram[16'h4003] = 8'h44;

        expect_sig("rst_halt", S_HALT, 16'd0);
        expect_sig("rst_dma",  S_DMA,  16'd0);
        expect_sig("rst_tof",  S_TOF,  16'd0);
        expect_sig("rst_ce",   S_CE,   16'd0);
        expect_sig("rst_we",   S_WE,   16'd0);
        expect_sig("rst_busy", S_BUSY, 16'd0);
        step(2);
        rst = 1'b1;

`ifndef VRAM_ARBITER_HOLD_TIMEOUT_EN
        run_burst();
        run_collision();
        run_back_to_back_and_saturation();
`else
        run_timeout();
`endif
        run_reset_mid_video();

        step(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
